blit_sequencer: RTL and testbench
=================================

Name: blit_sequencer

Overview:
- Command-level controller for the blitter pixel pipeline.
- Accepts one blit command (RECT fill, COPY, or TEXT expand) and walks the destination rectangle row by row.
- Emits one pixel descriptor per handshake into the memory-read stage, which feeds the colour stage. Each descriptor carries dst/src address, is_mem, is_text and bit_index.
- Owns all rectangle/stride arithmetic, so downstream stages stay pure per-pixel datapath.

Parameters:
- ADDR_W, 26, byte address width (dst and src).
- DIM_W, 12, width/height counter width (max 4095 pixels per axis).
- STRIDE_W, 16, row pitch width in bytes; zero-extended before add.

Ports:
- clock  input  1  system clock.
- resetn  input  1  asynchronous active-low reset.
- cmd_valid  input  1  command present.
- cmd_ready  output  1  sequencer idle, command accepted when cmd_valid && cmd_ready.
- cmd_op  input  2  0=RECT, 1=COPY, 2=TEXT, 3=reserved (treated as RECT).
- cmd_dst_addr  input  ADDR_W  top-left destination byte address.
- cmd_src_addr  input  ADDR_W  top-left source byte address (COPY/TEXT); ignored for RECT.
- cmd_width  input  DIM_W  pixels per row.
- cmd_height  input  DIM_W  rows.
- cmd_dst_stride  input  STRIDE_W  destination row pitch in bytes.
- cmd_src_stride  input  STRIDE_W  source row pitch in bytes (COPY: per pixel row; TEXT: per glyph row).
- abort  input  1  synchronous cancel of the current command.
- out_valid  output  1  pixel descriptor valid.
- out_ready  input  1  downstream accepts descriptor.
- out_dst_address  output  ADDR_W  pixel destination address.
- out_src_address  output  ADDR_W  source byte address.
- out_is_mem  output  1  1 for COPY/TEXT, 0 for RECT.
- out_is_text  output  1  1 for TEXT.
- out_bit_index  output  3  bit within source byte (TEXT), 0 otherwise.
- busy  output  1  state != IDLE.
- done  output  1  one-cycle pulse after last pixel handshake.

Behaviour:
- Reset (resetn low, async): state=IDLE; out_valid=0, done=0, busy=0, cmd_ready=1; all address/counter regs 0.
- States:
  - IDLE: cmd_ready=1. On accept, latch op, width, height and both strides. Set dst_row=cmd_dst_addr, src_row=cmd_src_addr, x=0, y=0.
    - width==0 or height==0: go to FIN, emitting no pixels.
    - Otherwise: go to RUN.
  - RUN: out_valid=1. Payload is registered and stable while out_valid && !out_ready.
    - On handshake when x==width-1 and y==height-1: go to FIN.
    - On handshake when x==width-1 (not last row): x=0, y+=1, dst_row+=dst_stride, src_row+=src_stride.
    - On other handshakes: x+=1.
  - FIN: done=1 for exactly one cycle, out_valid=0; then go to IDLE.
- Latency: first out_valid in the cycle after command accept. Maximum throughput is 1 pixel/clock with out_ready held high.
- Payload:
  - out_dst_address = dst_row + x.
  - RECT: out_src_address = src_row (don't-care), is_mem=0, is_text=0, bit_index=0.
  - COPY: out_src_address = src_row + x, is_mem=1, is_text=0, bit_index=0.
  - TEXT: out_src_address = src_row + (x>>3), is_mem=1, is_text=1, bit_index = x[2:0] (MSB-first downstream).
- Arithmetic: all address sums are modulo 2^ADDR_W (wrap silently). Strides are zero-extended. The x/y counters never exceed width-1/height-1.
- abort: valid in any state, takes priority over handshake. Next cycle state=IDLE, out_valid=0, no done pulse. A handshake in the abort cycle is still considered consumed by downstream.
- cmd_valid while busy is ignored (cmd_ready=0); the command must be held by the requester.
- Registered outputs only; no combinational path from out_ready to out_valid.

Test Plan:
- RECT dst=0x1000, w=3, h=2, stride=640, out_ready=1:
  - Expect 6 descriptors on consecutive cycles: dst 0x1000, 0x1001, 0x1002, 0x1280, 0x1281, 0x1282; is_mem=0.
  - done pulses the cycle after the 6th; busy low after.
- COPY src=0x2000, src_stride=16, dst=0x100, w=2, h=2, out_ready toggling 1/0:
  - src 0x2000, 0x2001, 0x2010, 0x2011 paired with dst 0x100, 0x101, 0x100+dst_stride, +1.
  - Payload held stable during stall cycles.
- TEXT src=0x3000, w=10, h=1:
  - bit_index 0..7 then 0..1.
  - src 0x3000 for x=0..7, 0x3001 for x=8..9; is_text=1.
- w=0, h=5: no out_valid ever; done pulses one cycle after accept; cmd_ready returns next cycle.
- Abort after 2 of 8 pixels: out_valid low the next cycle, no done; a new command accepted immediately restarts at its own dst_addr.
- Reset asserted mid-RUN (resetn=0 asynchronously): out_valid and busy drop without waiting for a clock edge; dst=0x3FFFFFF, w=2 after release produces dst 0x3FFFFFF then 0x0000000 (wrap).

Source files
------------

// File: rtl/blit_sequencer.sv
// Walks a blit command's destination rectangle and emits one pixel descriptor per out_valid/out_ready handshake.
// First descriptor appears the cycle after accept; 1 pixel/clock at full rate; payload holds steady while stalled.
module blit_sequencer #(
    parameter int ADDR_W   = 26,
    parameter int DIM_W    = 12,
    parameter int STRIDE_W = 16
) (
    input  logic                clock,
    input  logic                resetn,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [1:0]          cmd_op,
    input  logic [ADDR_W-1:0]   cmd_dst_addr,
    input  logic [ADDR_W-1:0]   cmd_src_addr,
    input  logic [DIM_W-1:0]    cmd_width,
    input  logic [DIM_W-1:0]    cmd_height,
    input  logic [STRIDE_W-1:0] cmd_dst_stride,
    input  logic [STRIDE_W-1:0] cmd_src_stride,
    input  logic                abort,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [ADDR_W-1:0]   out_dst_address,
    output logic [ADDR_W-1:0]   out_src_address,
    output logic                out_is_mem,
    output logic                out_is_text,
    output logic [2:0]          out_bit_index,
    output logic                busy,
    output logic                done
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIN  = 2'd2
    } state_t;

    localparam logic [1:0]       OP_COPY = 2'd1;
    localparam logic [1:0]       OP_TEXT = 2'd2;
    localparam logic [DIM_W-1:0] DIM_ONE = DIM_W'(1);

    state_t                state_q, state_d;
    logic                  is_mem_q, is_mem_d;
    logic                  is_text_q, is_text_d;
    logic [DIM_W-1:0]      width_q, width_d;
    logic [DIM_W-1:0]      height_q, height_d;
    logic [DIM_W-1:0]      x_q, x_d;
    logic [DIM_W-1:0]      y_q, y_d;
    logic [STRIDE_W-1:0]   dst_stride_q, dst_stride_d;
    logic [STRIDE_W-1:0]   src_stride_q, src_stride_d;
    logic [ADDR_W-1:0]     dst_row_q, dst_row_d;
    logic [ADDR_W-1:0]     src_row_q, src_row_d;
    logic [ADDR_W-1:0]     out_dst_q, out_dst_d;
    logic [ADDR_W-1:0]     out_src_q, out_src_d;
    logic [2:0]            bit_q, bit_d;
    logic                  last_col;
    logic                  last_row;

    assign last_col = (x_q == width_q - DIM_ONE);
    assign last_row = (y_q == height_q - DIM_ONE);

    always_comb begin
        state_d      = state_q;
        is_mem_d     = is_mem_q;
        is_text_d    = is_text_q;
        width_d      = width_q;
        height_d     = height_q;
        x_d          = x_q;
        y_d          = y_q;
        dst_stride_d = dst_stride_q;
        src_stride_d = src_stride_q;
        dst_row_d    = dst_row_q;
        src_row_d    = src_row_q;
        out_dst_d    = out_dst_q;
        out_src_d    = out_src_q;
        bit_d        = 3'd0;

        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    is_mem_d     = (cmd_op == OP_COPY) || (cmd_op == OP_TEXT);
                    is_text_d    = (cmd_op == OP_TEXT);
                    width_d      = cmd_width;
                    height_d     = cmd_height;
                    dst_stride_d = cmd_dst_stride;
                    src_stride_d = cmd_src_stride;
                    dst_row_d    = cmd_dst_addr;
                    src_row_d    = cmd_src_addr;
                    x_d          = '0;
                    y_d          = '0;
                    if ((cmd_width == '0) || (cmd_height == '0)) begin
                        state_d = ST_FIN;
                    end else begin
                        state_d = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                if (out_ready) begin
                    if (last_col && last_row) begin
                        state_d = ST_FIN;
                    end else if (last_col) begin
                        x_d       = '0;
                        y_d       = y_q + DIM_ONE;
                        dst_row_d = dst_row_q + ADDR_W'(dst_stride_q);
                        src_row_d = src_row_q + ADDR_W'(src_stride_q);
                    end else begin
                        x_d = x_q + DIM_ONE;
                    end
                end
            end
            ST_FIN: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Cancelling an in-flight command wins over any handshake this cycle.
        if (abort && (state_q != ST_IDLE)) begin
            state_d = ST_IDLE;
        end

        // Payload is precomputed from next-state so it is a pure register at the port.
        out_dst_d = dst_row_d + ADDR_W'(x_d);
        if (is_text_d) begin
            out_src_d = src_row_d + ADDR_W'(x_d >> 3);
            bit_d     = x_d[2:0];
        end else if (is_mem_d) begin
            out_src_d = src_row_d + ADDR_W'(x_d);
        end else begin
            out_src_d = src_row_d;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q      <= ST_IDLE;
            is_mem_q     <= 1'b0;
            is_text_q    <= 1'b0;
            width_q      <= '0;
            height_q     <= '0;
            x_q          <= '0;
            y_q          <= '0;
            dst_stride_q <= '0;
            src_stride_q <= '0;
            dst_row_q    <= '0;
            src_row_q    <= '0;
            out_dst_q    <= '0;
            out_src_q    <= '0;
            bit_q        <= 3'd0;
        end else begin
            state_q      <= state_d;
            is_mem_q     <= is_mem_d;
            is_text_q    <= is_text_d;
            width_q      <= width_d;
            height_q     <= height_d;
            x_q          <= x_d;
            y_q          <= y_d;
            dst_stride_q <= dst_stride_d;
            src_stride_q <= src_stride_d;
            dst_row_q    <= dst_row_d;
            src_row_q    <= src_row_d;
            out_dst_q    <= out_dst_d;
            out_src_q    <= out_src_d;
            bit_q        <= bit_d;
        end
    end

    assign cmd_ready       = (state_q == ST_IDLE);
    assign busy            = (state_q != ST_IDLE);
    assign out_valid       = (state_q == ST_RUN);
    assign done            = (state_q == ST_FIN);
    assign out_dst_address = out_dst_q;
    assign out_src_address = out_src_q;
    assign out_is_mem      = is_mem_q;
    assign out_is_text     = is_text_q;
    assign out_bit_index   = bit_q;

endmodule

// File: tb/tb_blit_sequencer.sv
// Table-driven bench for blit_sequencer with an expected-descriptor scoreboard queue.
`timescale 1ns/1ps
module tb_blit_sequencer;

    localparam int AW = 26;
    localparam int DW = 12;
    localparam int SW = 16;

    logic          clock = 1'b0;
    logic          resetn = 1'b0;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [1:0]    cmd_op = '0;
    logic [AW-1:0] cmd_dst_addr = '0;
    logic [AW-1:0] cmd_src_addr = '0;
    logic [DW-1:0] cmd_width = '0;
    logic [DW-1:0] cmd_height = '0;
    logic [SW-1:0] cmd_dst_stride = '0;
    logic [SW-1:0] cmd_src_stride = '0;
    logic          abort = 1'b0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [AW-1:0] out_dst_address;
    logic [AW-1:0] out_src_address;
    logic          out_is_mem;
    logic          out_is_text;
    logic [2:0]    out_bit_index;
    logic          busy;
    logic          done;

    blit_sequencer dut (
        .clock(clock), .resetn(resetn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_dst_addr(cmd_dst_addr), .cmd_src_addr(cmd_src_addr),
        .cmd_width(cmd_width), .cmd_height(cmd_height),
        .cmd_dst_stride(cmd_dst_stride), .cmd_src_stride(cmd_src_stride),
        .abort(abort), .out_valid(out_valid), .out_ready(out_ready),
        .out_dst_address(out_dst_address), .out_src_address(out_src_address),
        .out_is_mem(out_is_mem), .out_is_text(out_is_text),
        .out_bit_index(out_bit_index), .busy(busy), .done(done)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [1:0]    op;
        logic [AW-1:0] dst;
        logic [AW-1:0] src;
        logic [DW-1:0] w;
        logic [DW-1:0] h;
        logic [SW-1:0] ds;
        logic [SW-1:0] ss;
        int            rdy_mode;      // 0 always ready, 1 toggling, 2 random
        int            exp_pix;
        logic [AW-1:0] exp_first_dst;
    } vec_t;

    typedef struct packed {
        logic [AW-1:0] dst;
        logic [AW-1:0] src;
        logic          mem;
        logic          text;
        logic [2:0]    bidx;
    } desc_t;

    desc_t exp_q[$];
    vec_t  tbl[8];
    int    total = 0;
    int    bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    function automatic desc_t cur_desc();
        desc_t d;
        d.dst  = out_dst_address;
        d.src  = out_is_mem ? out_src_address : '0;
        d.mem  = out_is_mem;
        d.text = out_is_text;
        d.bidx = out_bit_index;
        return d;
    endfunction

    // Reference model: closed-form address arithmetic, truncated to AW bits.
    task automatic push_expected(input vec_t v);
        for (int y = 0; y < int'(v.h); y++) begin
            for (int x = 0; x < int'(v.w); x++) begin
                desc_t       d;
                logic [63:0] t;
                t     = 64'(v.dst) + 64'(y) * 64'(v.ds) + 64'(x);
                d.dst = t[AW-1:0];
                case (v.op)
                    2'd1:    t = 64'(v.src) + 64'(y) * 64'(v.ss) + 64'(x);
                    2'd2:    t = 64'(v.src) + 64'(y) * 64'(v.ss) + 64'(x / 8);
                    default: t = '0;
                endcase
                d.src  = t[AW-1:0];
                d.mem  = (v.op == 2'd1) || (v.op == 2'd2);
                d.text = (v.op == 2'd2);
                d.bidx = (v.op == 2'd2) ? 3'(x % 8) : 3'd0;
                exp_q.push_back(d);
            end
        end
    endtask

    task automatic drive_cmd(input vec_t v);
        cmd_op         = v.op;
        cmd_dst_addr   = v.dst;
        cmd_src_addr   = v.src;
        cmd_width      = v.w;
        cmd_height     = v.h;
        cmd_dst_stride = v.ds;
        cmd_src_stride = v.ss;
        cmd_valid      = 1'b1;
        push_expected(v);
    endtask

    task automatic pop_compare(input string name);
        desc_t e;
        if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL %s: descriptor %0h with empty scoreboard", name, cur_desc());
        end else begin
            e = exp_q.pop_front();
            check(name, cur_desc(), e);
        end
    endtask

    // Called on a negedge; returns on a negedge after the command has completed.
    task automatic run_cmd(input vec_t v, input string tag);
        int    cyc;
        int    npix;
        bit    hold_v;
        bit    rdy;
        bit    finished;
        desc_t held;
        cyc = 0;
        while (!cmd_ready && cyc < 50) begin
            @(negedge clock);
            cyc++;
        end
        check({tag, " cmd_ready"}, cmd_ready, 1'b1);
        drive_cmd(v);
        out_ready = 1'b0;
        npix = 0;
        hold_v = 1'b0;
        finished = 1'b0;
        for (cyc = 1; cyc < 3000 && !finished; cyc++) begin
            @(negedge clock);
            cmd_valid = 1'b0;
            if (cyc == 1)
                check({tag, " first_valid"}, out_valid, v.exp_pix > 0);
            if (done) begin
                finished = 1'b1;
                check({tag, " done_outvalid"}, out_valid, 1'b0);
                check({tag, " queue_empty"}, 64'(exp_q.size()), 64'd0);
                if (v.rdy_mode == 0)
                    check({tag, " done_cycle"}, 64'(cyc), 64'(v.exp_pix + 1));
            end else begin
                if (hold_v && out_valid)
                    check({tag, " stall_stable"}, cur_desc(), held);
                case (v.rdy_mode)
                    0:       rdy = 1'b1;
                    1:       rdy = cyc[0];
                    default: rdy = 1'($urandom_range(0, 1));
                endcase
                out_ready = rdy;
                if (out_valid) begin
                    if (rdy) begin
                        if (npix == 0)
                            check({tag, " first_dst"}, out_dst_address, v.exp_first_dst);
                        pop_compare({tag, " desc"});
                        npix++;
                        hold_v = 1'b0;
                    end else begin
                        held = cur_desc();
                        hold_v = 1'b1;
                    end
                end
            end
        end
        if (!finished) begin
            total++;
            bad++;
            $display("FAIL %s timeout: no done after %0d cycles", tag, cyc);
        end
        check({tag, " pixel_count"}, 64'(npix), 64'(v.exp_pix));
        out_ready = 1'b0;
        @(negedge clock);
        check({tag, " done_pulse_len"}, done, 1'b0);
        check({tag, " busy_after"}, busy, 1'b0);
        check({tag, " ready_after"}, cmd_ready, 1'b1);
        exp_q.delete();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;
        tbl[0] = '{2'd0, 26'h1000,    26'h0,       12'd3,  12'd2, 16'd640,    16'd0,      0, 6,  26'h1000};
        tbl[1] = '{2'd1, 26'h100,     26'h2000,    12'd2,  12'd2, 16'h40,     16'd16,     1, 4,  26'h100};
        tbl[2] = '{2'd2, 26'h800,     26'h3000,    12'd10, 12'd1, 16'd0,      16'd1,      0, 10, 26'h800};
        tbl[3] = '{2'd0, 26'h1234,    26'h0,       12'd0,  12'd5, 16'd64,     16'd0,      0, 0,  26'h0};
        tbl[4] = '{2'd3, 26'h20,      26'h555,     12'd2,  12'd3, 16'h100,    16'd7,      2, 6,  26'h20};
        tbl[5] = '{2'd2, 26'h4000,    26'h3FFFFFE, 12'd17, 12'd3, 16'h200,    16'd3,      2, 51, 26'h4000};
        tbl[6] = '{2'd1, 26'h3FFFF00, 26'h10,      12'd5,  12'd4, 16'hFFFF,   16'h8000,   1, 20, 26'h3FFFF00};
        tbl[7] = '{2'd1, 26'h77,      26'h88,      12'd3,  12'd0, 16'd1,      16'd1,      0, 0,  26'h0};

        #12;
        check("reset out_valid", out_valid, 1'b0);
        check("reset done", done, 1'b0);
        check("reset busy", busy, 1'b0);
        check("reset cmd_ready", cmd_ready, 1'b1);
        @(negedge clock);
        resetn = 1'b1;
        @(negedge clock);

        for (int i = 0; i < 8; i++) begin
            run_cmd(tbl[i], $sformatf("vec%0d", i));
        end

        // Abort after two of eight pixels, then restart immediately.
        v = '{2'd0, 26'h500, 26'h0, 12'd8, 12'd1, 16'd0, 16'd0, 0, 8, 26'h500};
        drive_cmd(v);
        @(negedge clock);
        cmd_valid = 1'b0;
        out_ready = 1'b1;
        check("abort px0 valid", out_valid, 1'b1);
        pop_compare("abort px0");
        @(negedge clock);
        pop_compare("abort px1");
        @(negedge clock);
        out_ready = 1'b0;
        abort = 1'b1;
        @(negedge clock);
        abort = 1'b0;
        check("abort out_valid", out_valid, 1'b0);
        check("abort no_done", done, 1'b0);
        check("abort busy", busy, 1'b0);
        check("abort cmd_ready", cmd_ready, 1'b1);
        exp_q.delete();
        v = '{2'd1, 26'h900, 26'hA00, 12'd3, 12'd1, 16'd0, 16'd0, 0, 3, 26'h900};
        run_cmd(v, "after_abort");

        // Asynchronous reset in the middle of a run.
        v = '{2'd0, 26'h40, 26'h0, 12'd4, 12'd4, 16'h10, 16'd0, 0, 16, 26'h40};
        drive_cmd(v);
        @(negedge clock);
        cmd_valid = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(negedge clock);
        check("pre_reset busy", busy, 1'b1);
        #2;
        resetn = 1'b0;
        #1;
        check("async_reset out_valid", out_valid, 1'b0);
        check("async_reset busy", busy, 1'b0);
        check("async_reset cmd_ready", cmd_ready, 1'b1);
        exp_q.delete();
        out_ready = 1'b0;
        @(negedge clock);
        resetn = 1'b1;
        @(negedge clock);
        v = '{2'd0, 26'h3FFFFFF, 26'h0, 12'd2, 12'd1, 16'd0, 16'd0, 0, 2, 26'h3FFFFFF};
        run_cmd(v, "wrap");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
